soc_ctrl_boot_seq: RTL
======================

Name: soc_ctrl_boot_seq

Overview:
- Hardware boot sequencer. It is the bus initiator that programs the SoC control register block after power-on.
- Issues a fixed series of single-beat register writes and one read to the soc_ctrl register slave:
  - PLL configs,
  - wait for PLL lock,
  - clock/reset releases,
  - boot address and hart ID setup,
  - core release.
- Sits between the always-on reset domain and the soc_ctrl slave port. Reports done/error status to the top level.

Parameters:
- SOC_CTRL_BASE, dual_helix_pkg::SOC_CTRL_BASE, base byte address of the soc_ctrl register block.
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- REF_DIV_BW, 4, PLL reference divider width.
- FB_DIV_BW, 12, PLL feedback divider width.
- LOCK_TIMEOUT, 1024, maximum cycles spent in WAIT_LOCK.
- BOOT_MODE_W, 2, width of captured boot mode.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle start pulse
- pll_ref_div_i  in  3*REF_DIV_BW  ref dividers {core1, core0, sys_link}
- pll_fb_div_i  in  3*FB_DIV_BW  fb dividers {core1, core0, sys_link}
- pll_locked_i  in  3  lock flags {core1, core0, sys_link}
- boot_addr_c0_i  in  DATA_W  core 0 boot address
- boot_addr_c1_i  in  DATA_W  core 1 boot address
- req_valid_o  out  1  request valid
- req_ready_i  in  1  slave accepts request
- req_we_o  out  1  1=write, 0=read
- req_addr_o  out  ADDR_W  byte address
- req_wdata_o  out  DATA_W  write data
- rsp_valid_i  in  1  response valid
- rsp_err_i  in  1  response error
- rsp_rdata_i  in  DATA_W  read data
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence completed (sticky)
- error_o  out  1  sequence aborted (sticky)
- err_step_o  out  4  step index at abort; 0xF = lock timeout
- boot_mode_o  out  BOOT_MODE_W  captured BOOT_MODE[BOOT_MODE_W-1:0]

Behaviour:
- Reset (rst_i high at posedge): state IDLE, step=0. All outputs 0, including req_valid_o, busy_o, done_o, error_o, err_step_o and boot_mode_o.
- Reset mid-transaction drops req_valid_o on that same edge. The slave is reset together with this block.
- FSM states: IDLE, ISSUE, WAIT_RSP, WAIT_LOCK, DONE, ERROR.
- start_i is accepted only in IDLE, DONE or ERROR.
  - On acceptance: step=0, clear done_o/error_o/err_step_o, go to ISSUE.
  - start_i in ISSUE, WAIT_RSP or WAIT_LOCK is ignored.
- busy_o = 1 in ISSUE, WAIT_RSP and WAIT_LOCK.
- Request handshake:
  - In ISSUE, req_valid_o=1 with addr/we/wdata driven from the step table.
  - These stay stable until req_valid_o & req_ready_i; then go to WAIT_RSP next cycle with req_valid_o=0.
  - Exactly one outstanding request at a time. No request timeout.
- Response: in WAIT_RSP, wait for rsp_valid_i. rsp_valid_i outside WAIT_RSP is ignored.
  - If rsp_err_i: go to ERROR, err_step_o=step, error_o=1.
  - Otherwise, if step 6 is a read, capture rsp_rdata_i into boot_mode_o.
  - Then increment step:
    - step 2 done → WAIT_LOCK;
    - step 12 done → DONE (done_o=1);
    - otherwise → ISSUE.
- Step table (address = SOC_CTRL_BASE + offset; all writes except step 6):
  - 0: 0x340 PLL sys_link, wdata = {zero, fb[11:0], ref[3:0]}
  - 1: 0x2C0 PLL core0, same format
  - 2: 0x300 PLL core1, same format
  - 3: 0x240 CLK_RST sys_link = 0x3 (bit0 clk_en, bit1 rst_n)
  - 4: 0x280 CLK_RST periph_link = 0x3
  - 5: 0x200 CLK_RST core_link = 0x3
  - 6: 0x400 BOOT_MODE read, wdata=0
  - 7: 0x000 boot_addr_c0_i
  - 8: 0x040 boot_addr_c1_i
  - 9: 0x080 HARD_ID core0 = 0
  - 10: 0x0C0 HARD_ID core1 = 1
  - 11: 0x180 CLK_RST core0 = 0x3
  - 12: 0x1C0 CLK_RST core1 = 0x3
- WAIT_LOCK:
  - Counter cleared on entry.
  - If pll_locked_i==3'b111 (sampled each cycle), go to ISSUE with step=3.
  - Else the counter increments. If the counter reaches LOCK_TIMEOUT-1 while still unlocked: go to ERROR, err_step_o=0xF.
  - Lock in the same cycle the counter hits the limit: lock wins.
- Divider and boot address inputs are sampled when the corresponding request is issued (not latched at start).
- Latency, zero-wait slave (ready=1, rsp the next cycle) and lock already high: 2 cycles per step + 1 cycle WAIT_LOCK. DONE is reached 27 cycles after start.

Test Plan:
- Happy path: ready=1, 1-cycle rsp, locked=3'b111, BOOT_MODE rdata=0x2.
  - → 13 requests with the exact addresses/data of the table in order.
  - → done_o=1 after 27 cycles; boot_mode_o=2; error_o=0.
- Backpressure: req_ready_i low for 5 cycles on step 0.
  - → req_valid_o, addr=BASE+0x340 and wdata stay stable for all 5 cycles. Sequence then completes.
- Lock timeout: LOCK_TIMEOUT=16, pll_locked_i=3'b011 constant.
  - → error_o=1, err_step_o=0xF after 16 WAIT_LOCK cycles.
  - → No request at 0x240 is ever issued.
- Slave error: rsp_err_i=1 on step 4 (0x280).
  - → error_o=1, err_step_o=4, busy_o=0, no further requests.
  - → A subsequent start_i restarts at step 0 with error_o cleared.
- start_i pulsed while in WAIT_RSP on step 8 → ignored; the sequence continues unchanged to DONE.
- rst_i asserted during step 7 ISSUE.
  - → Next cycle: req_valid_o=0, all outputs 0, state IDLE.
  - → A new start_i runs the full sequence from step 0.

Source files
------------

// File: rtl/dual_helix_pkg.sv
// dual_helix_pkg: SoC-wide address map constants shared by the control blocks
package dual_helix_pkg;

    localparam logic [31:0] SOC_CTRL_BASE = 32'h1A10_0000;

endpackage

// File: rtl/soc_ctrl_boot_seq.sv
// soc_ctrl_boot_seq: post-reset bus initiator that programs the soc_ctrl register block
module soc_ctrl_boot_seq #(
    parameter logic [31:0] SOC_CTRL_BASE = dual_helix_pkg::SOC_CTRL_BASE,
    parameter int          ADDR_W        = 32,
    parameter int          DATA_W        = 32,
    parameter int          REF_DIV_BW    = 4,
    parameter int          FB_DIV_BW     = 12,
    parameter int          LOCK_TIMEOUT  = 1024,
    parameter int          BOOT_MODE_W   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [3*REF_DIV_BW-1:0] pll_ref_div_i,
    input  logic [3*FB_DIV_BW-1:0]  pll_fb_div_i,
    input  logic [2:0]              pll_locked_i,
    input  logic [DATA_W-1:0]       boot_addr_c0_i,
    input  logic [DATA_W-1:0]       boot_addr_c1_i,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic                    req_we_o,
    output logic [ADDR_W-1:0]       req_addr_o,
    output logic [DATA_W-1:0]       req_wdata_o,
    input  logic                    rsp_valid_i,
    input  logic                    rsp_err_i,
    input  logic [DATA_W-1:0]       rsp_rdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [3:0]              err_step_o,
    output logic [BOOT_MODE_W-1:0]  boot_mode_o
);

    localparam int                CNT_W     = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(SOC_CTRL_BASE);
    localparam logic [3:0]        STEP_LOCK = 4'd2;
    localparam logic [3:0]        STEP_READ = 4'd6;
    localparam logic [3:0]        STEP_LAST = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        WAIT_LOCK,
        DONE,
        ERROR
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             step_q, step_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [3:0]             err_step_q, err_step_d;
    logic [BOOT_MODE_W-1:0] boot_mode_q, boot_mode_d;

    logic [11:0]            tbl_off;
    logic [DATA_W-1:0]      tbl_wdata;
    logic                   tbl_we;
    logic [DATA_W-1:0]      pll_sys_w, pll_c0_w, pll_c1_w;
    logic                   unused_rdata;

    // PLL config words are {fb, ref} of the matching divider slice, taken live at issue time
    assign pll_sys_w = DATA_W'({pll_fb_div_i[FB_DIV_BW-1:0],
                                pll_ref_div_i[REF_DIV_BW-1:0]});
    assign pll_c0_w  = DATA_W'({pll_fb_div_i[2*FB_DIV_BW-1:FB_DIV_BW],
                                pll_ref_div_i[2*REF_DIV_BW-1:REF_DIV_BW]});
    assign pll_c1_w  = DATA_W'({pll_fb_div_i[3*FB_DIV_BW-1:2*FB_DIV_BW],
                                pll_ref_div_i[3*REF_DIV_BW-1:2*REF_DIV_BW]});

    assign unused_rdata = ^rsp_rdata_i[DATA_W-1:BOOT_MODE_W];

    // Step table: register offset, write data and direction for the current step
    always_comb begin
        tbl_off   = '0;
        tbl_wdata = '0;
        tbl_we    = 1'b1;
        case (step_q)
            4'd0:  begin tbl_off = 12'h340; tbl_wdata = pll_sys_w;      end
            4'd1:  begin tbl_off = 12'h2C0; tbl_wdata = pll_c0_w;       end
            4'd2:  begin tbl_off = 12'h300; tbl_wdata = pll_c1_w;       end
            4'd3:  begin tbl_off = 12'h240; tbl_wdata = DATA_W'(3);     end
            4'd4:  begin tbl_off = 12'h280; tbl_wdata = DATA_W'(3);     end
            4'd5:  begin tbl_off = 12'h200; tbl_wdata = DATA_W'(3);     end
            4'd6:  begin tbl_off = 12'h400; tbl_we    = 1'b0;           end
            4'd7:  begin tbl_off = 12'h000; tbl_wdata = boot_addr_c0_i; end
            4'd8:  begin tbl_off = 12'h040; tbl_wdata = boot_addr_c1_i; end
            4'd9:  begin tbl_off = 12'h080; tbl_wdata = DATA_W'(0);     end
            4'd10: begin tbl_off = 12'h0C0; tbl_wdata = DATA_W'(1);     end
            4'd11: begin tbl_off = 12'h180; tbl_wdata = DATA_W'(3);     end
            4'd12: begin tbl_off = 12'h1C0; tbl_wdata = DATA_W'(3);     end
            default: begin tbl_off = '0; tbl_wdata = '0; tbl_we = 1'b1; end
        endcase
    end

    // Next-state logic: start acceptance, handshake, response handling and lock wait
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        error_d     = error_q;
        err_step_d  = err_step_q;
        boot_mode_d = boot_mode_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    state_d    = ISSUE;
                    step_d     = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_step_d = '0;
                end
            end
            ISSUE: begin
                if (req_ready_i) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_valid_i) begin
                    if (rsp_err_i) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        err_step_d = step_q;
                    end else begin
                        if (step_q == STEP_READ) boot_mode_d = rsp_rdata_i[BOOT_MODE_W-1:0];
                        step_d = step_q + 4'd1;
                        if (step_q == STEP_LOCK) begin
                            state_d = WAIT_LOCK;
                            cnt_d   = '0;
                        end else if (step_q == STEP_LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
            end
            WAIT_LOCK: begin
                if (pll_locked_i == 3'b111) begin
                    state_d = ISSUE;
                    step_d  = 4'd3;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = ERROR;
                    error_d    = 1'b1;
                    err_step_d = 4'hF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_step_q  <= '0;
            boot_mode_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_step_q  <= err_step_d;
            boot_mode_q <= boot_mode_d;
        end
    end

    assign req_valid_o = state_q == ISSUE;
    assign req_we_o    = req_valid_o & tbl_we;
    assign req_addr_o  = req_valid_o ? BASE + ADDR_W'(tbl_off) : '0;
    assign req_wdata_o = req_valid_o ? tbl_wdata : '0;
    assign busy_o      = state_q == ISSUE || state_q == WAIT_RSP || state_q == WAIT_LOCK;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_step_o  = err_step_q;
    assign boot_mode_o = boot_mode_q;

endmodule
